// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the Morse element controller.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        WAIT_WORD
    } ctrl_state_t;

    typedef enum logic {
        ELEM_DOT  = 1'b0,
        ELEM_DASH = 1'b1
    } elem_t;

    localparam int unsigned DEF_UNIT_TICKS       = 1000;
    localparam int unsigned DEF_DASH_UNITS       = 2;
    localparam int unsigned DEF_LETTER_GAP_UNITS = 3;
    localparam int unsigned DEF_WORD_GAP_UNITS   = 7;
    localparam int unsigned DEF_MAX_UNITS        = 15;
    localparam int unsigned DEF_MAX_ELEMS        = 6;

endpackage

// File: rtl/unit_counter.sv
// Tick prescaler feeding a saturating Morse-unit counter, with a threshold compare.
module unit_counter
    import morse_pkg::*;
#(
    parameter  int unsigned UNIT_TICKS = DEF_UNIT_TICKS,
    parameter  int unsigned MAX_UNITS  = DEF_MAX_UNITS,
    localparam int unsigned UNIT_W     = $clog2(MAX_UNITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              count_cur,
    input  logic [UNIT_W-1:0] thresh,
    output logic [UNIT_W-1:0] units_o,
    output logic              reached_o
);

    localparam int unsigned       TICK_W    = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_TICKS - 1);
    localparam logic [UNIT_W-1:0] UNIT_SAT  = UNIT_W'(MAX_UNITS);

    logic [TICK_W-1:0] tick_cnt;
    logic [UNIT_W-1:0] unit_cnt;
    logic [UNIT_W-1:0] unit_next;
    logic              tick_wrap;

    // count_cur folds the sample being taken this cycle into the compare,
    // so a threshold is seen on the very sample that completes it.
    always_comb begin
        tick_wrap = (tick_cnt == TICK_LAST);
        unit_next = unit_cnt;
        if (tick_wrap && (unit_cnt != UNIT_SAT)) begin
            unit_next = unit_cnt + UNIT_W'(1);
        end
        reached_o = ((count_cur ? unit_next : unit_cnt) >= thresh);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            unit_cnt <= '0;
        end else if (load) begin
            tick_cnt <= TICK_W'(1);
            unit_cnt <= '0;
        end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
            unit_cnt <= unit_next;
        end
    end

    assign units_o = unit_cnt;

endmodule

// File: rtl/morse_element_ctrl.sv
// Classifies debounced key intervals into dot/dash/letter/word events and
// assembles the element pattern of each letter for the character decoder.
module morse_element_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_TICKS       = DEF_UNIT_TICKS,
    parameter int unsigned DASH_UNITS       = DEF_DASH_UNITS,
    parameter int unsigned LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
    parameter int unsigned WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS,
    parameter int unsigned MAX_UNITS        = DEF_MAX_UNITS,
    parameter int unsigned MAX_ELEMS        = DEF_MAX_ELEMS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               key_i,
    output logic                               dot_o,
    output logic                               dash_o,
    output logic                               letter_end_o,
    output logic [MAX_ELEMS-1:0]               letter_code_o,
    output logic [$clog2(MAX_ELEMS+1)-1:0]     letter_len_o,
    output logic                               letter_err_o,
    output logic                               word_end_o,
    output logic                               busy_o
);

    localparam int unsigned       UNIT_W    = $clog2(MAX_UNITS + 1);
    localparam int unsigned       LEN_W     = $clog2(MAX_ELEMS + 1);
    localparam logic [UNIT_W-1:0] DASH_TH   = UNIT_W'(DASH_UNITS);
    localparam logic [UNIT_W-1:0] LETTER_TH = UNIT_W'(LETTER_GAP_UNITS);
    localparam logic [UNIT_W-1:0] WORD_TH   = UNIT_W'(WORD_GAP_UNITS);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_ELEMS);

    ctrl_state_t          state;
    logic                 key_prev;
    logic [MAX_ELEMS-1:0] code;
    logic [LEN_W-1:0]     len;
    logic                 err;

    logic [UNIT_W-1:0]    units;
    logic [UNIT_W-1:0]    gap_thresh;
    logic                 gap_reached;
    logic                 key_rise;
    logic                 cnt_load;
    elem_t                elem;

    always_comb begin
        key_rise   = key_i && !key_prev;
        elem       = (units >= DASH_TH) ? ELEM_DASH : ELEM_DOT;
        gap_thresh = (state == WAIT_WORD) ? WORD_TH : LETTER_TH;
        cnt_load   = 1'b0;
        case (state)
            IDLE:           cnt_load = key_rise;
            PRESS:          cnt_load = !key_i;
            GAP, WAIT_WORD: cnt_load = key_i;
            default:        cnt_load = 1'b0;
        endcase
    end

    // Only key-up samples count toward a gap; a key-down sample is compared
    // against the gap already accumulated.
    unit_counter #(
        .UNIT_TICKS (UNIT_TICKS),
        .MAX_UNITS  (MAX_UNITS)
    ) u_unit_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .count_cur (!key_i),
        .thresh    (gap_thresh),
        .units_o   (units),
        .reached_o (gap_reached)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            key_prev      <= 1'b1;
            code          <= '0;
            len           <= '0;
            err           <= 1'b0;
            dot_o         <= 1'b0;
            dash_o        <= 1'b0;
            letter_end_o  <= 1'b0;
            letter_code_o <= '0;
            letter_len_o  <= '0;
            letter_err_o  <= 1'b0;
            word_end_o    <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            key_prev      <= key_i;
            dot_o         <= 1'b0;
            dash_o        <= 1'b0;
            letter_end_o  <= 1'b0;
            letter_code_o <= '0;
            letter_len_o  <= '0;
            letter_err_o  <= 1'b0;
            word_end_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (key_rise) begin
                        state  <= PRESS;
                        busy_o <= 1'b1;
                    end
                end

                PRESS: begin
                    if (!key_i) begin
                        dot_o  <= (elem == ELEM_DOT);
                        dash_o <= (elem == ELEM_DASH);
                        if (len == LEN_MAX) begin
                            err <= 1'b1;
                        end else begin
                            code <= MAX_ELEMS'({code, logic'(elem)});
                            len  <= len + LEN_W'(1);
                        end
                        state <= GAP;
                    end
                end

                GAP: begin
                    if (gap_reached) begin
                        letter_end_o  <= 1'b1;
                        letter_code_o <= code;
                        letter_len_o  <= len;
                        letter_err_o  <= err;
                        code          <= '0;
                        len           <= '0;
                        err           <= 1'b0;
                    end
                    if (key_i) begin
                        state <= PRESS;
                    end else if (gap_reached) begin
                        state <= WAIT_WORD;
                    end
                end

                WAIT_WORD: begin
                    if (gap_reached) begin
                        word_end_o <= 1'b1;
                    end
                    if (key_i) begin
                        state <= PRESS;
                    end else if (gap_reached) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_element_ctrl.sv
// Directed bench for morse_element_ctrl with a 4-tick unit.
module tb_morse_element_ctrl;

    logic       clk;
    logic       reset;
    logic       key_i;
    logic       dot_o;
    logic       dash_o;
    logic       letter_end_o;
    logic [5:0] letter_code_o;
    logic [2:0] letter_len_o;
    logic       letter_err_o;
    logic       word_end_o;
    logic       busy_o;

    int n_vec  = 0;
    int n_fail = 0;
    int n_dot, n_dash, n_let, n_word, n_any, n_busy, n_multi;
    logic [5:0] last_code;
    logic [2:0] last_len;
    logic       last_err;

    morse_element_ctrl #(
        .UNIT_TICKS       (4),
        .DASH_UNITS       (2),
        .LETTER_GAP_UNITS (3),
        .WORD_GAP_UNITS   (7),
        .MAX_UNITS        (15),
        .MAX_ELEMS        (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_i         (key_i),
        .dot_o         (dot_o),
        .dash_o        (dash_o),
        .letter_end_o  (letter_end_o),
        .letter_code_o (letter_code_o),
        .letter_len_o  (letter_len_o),
        .letter_err_o  (letter_err_o),
        .word_end_o    (word_end_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_dot = 0; n_dash = 0; n_let = 0; n_word = 0;
        n_any = 0; n_busy = 0;
        last_code = '0; last_len = '0; last_err = 1'b0;
    endtask

    // One clock with key level k; outputs are observed 1 time unit after the edge.
    task automatic cyc(input logic k);
        key_i = k;
        @(posedge clk);
        #1;
        if (dot_o)  n_dot++;
        if (dash_o) n_dash++;
        if (word_end_o) n_word++;
        if (letter_end_o) begin
            n_let++;
            last_code = letter_code_o;
            last_len  = letter_len_o;
            last_err  = letter_err_o;
        end
        if (dot_o || dash_o || letter_end_o || word_end_o || letter_err_o ||
            (|letter_code_o) || (|letter_len_o)) n_any++;
        if (busy_o) n_busy++;
        if ($countones({dot_o, dash_o, letter_end_o, word_end_o}) > 1) n_multi++;
    endtask

    task automatic run(input logic k, input int n);
        for (int i = 0; i < n; i++) cyc(k);
    endtask

    initial begin
        n_multi = 0;
        clr_counts();
        reset = 1'b1;
        key_i = 1'b1;

        // 1: key held through reset release is ignored
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 32'({dot_o, dash_o, letter_end_o, letter_code_o, letter_len_o,
                               letter_err_o, word_end_o, busy_o}), 32'd0);
        reset = 1'b0;
        run(1'b1, 20);
        run(1'b0, 40);
        check("held_any", n_any, 0);
        check("held_busy", n_busy, 0);

        // 2: 4 -> dot, 7 -> dot, 8 -> dash
        clr_counts();
        run(1'b1, 4); cyc(1'b0);
        check("t2_dot4", 32'({dot_o, dash_o}), 32'b10);
        run(1'b0, 3);
        run(1'b1, 7); cyc(1'b0);
        check("t2_dot7", 32'({dot_o, dash_o}), 32'b10);
        run(1'b0, 3);
        run(1'b1, 8); cyc(1'b0);
        check("t2_dash8", 32'({dot_o, dash_o}), 32'b01);
        run(1'b0, 3);
        check("t2_no_let", n_let, 0);
        check("t2_counts", 32'({n_dot[3:0], n_dash[3:0]}), 32'h21);
        run(1'b0, 30);
        check("t2_letter", 32'({last_code, last_len, last_err}), 32'({6'b000001, 3'd3, 1'b0}));
        check("t2_word", 32'({n_let[3:0], n_word[3:0]}), 32'h11);
        check("t2_idle", 32'(busy_o), 32'd0);

        // 3: dot, dash, letter end exactly on 12th low sample
        clr_counts();
        run(1'b1, 4); cyc(1'b0); run(1'b0, 3);
        run(1'b1, 8); cyc(1'b0); run(1'b0, 10);
        check("t3_pre12", n_let, 0);
        cyc(1'b0);
        check("t3_let12", 32'(letter_end_o), 32'd1);
        check("t3_code", 32'({letter_code_o, letter_len_o, letter_err_o}),
              32'({6'b000001, 3'd2, 1'b0}));
        run(1'b0, 20);

        // 4: single dot, letter at 12, word at 28
        clr_counts();
        run(1'b1, 4); cyc(1'b0); run(1'b0, 10);
        cyc(1'b0);
        check("t4_let", 32'({letter_end_o, letter_code_o, letter_len_o}),
              32'({1'b1, 6'b000000, 3'd1}));
        run(1'b0, 15);
        check("t4_pre28", n_word, 0);
        cyc(1'b0);
        check("t4_word28", 32'({word_end_o, busy_o}), 32'b10);

        // 4b: 11 low cycles between dots stays within one letter
        clr_counts();
        run(1'b1, 4); cyc(1'b0); run(1'b0, 10);
        run(1'b1, 4); cyc(1'b0);
        check("t4b_dot2", 32'(dot_o), 32'd1);
        check("t4b_no_let", n_let, 0);
        run(1'b0, 10); cyc(1'b0);
        check("t4b_let", 32'({letter_end_o, letter_code_o, letter_len_o}),
              32'({1'b1, 6'b000000, 3'd2}));
        run(1'b0, 20);

        // 5: seven dots overflow the element limit
        clr_counts();
        for (int d = 0; d < 7; d++) begin
            run(1'b1, 4); cyc(1'b0); run(1'b0, 3);
        end
        check("t5_dots", n_dot, 7);
        run(1'b0, 7); cyc(1'b0);
        check("t5_err", 32'({letter_end_o, letter_code_o, letter_len_o, letter_err_o}),
              32'({1'b1, 6'b000000, 3'd6, 1'b1}));
        run(1'b0, 20);
        clr_counts();
        run(1'b1, 8); cyc(1'b0); run(1'b0, 10); cyc(1'b0);
        check("t5_next", 32'({letter_end_o, letter_code_o, letter_len_o, letter_err_o}),
              32'({1'b1, 6'b000001, 3'd1, 1'b0}));
        run(1'b0, 20);

        // 6: long presses saturate rather than wrap
        clr_counts();
        run(1'b1, 100); cyc(1'b0);
        check("t6_dash100", 32'({dot_o, dash_o}), 32'b01);
        run(1'b0, 30);
        run(1'b1, 68); cyc(1'b0);
        check("t6_dash68", 32'({dot_o, dash_o}), 32'b01);
        run(1'b0, 30);
        check("t6_counts", 32'({n_dot[3:0], n_dash[3:0], n_let[3:0]}), 32'h022);

        // 6b: asynchronous reset right after a dash pulse
        run(1'b1, 8); cyc(1'b0);
        check("t6b_pre", 32'({dash_o, busy_o}), 32'b11);
        #1 reset = 1'b1;
        #1;
        check("t6b_clr", 32'({dot_o, dash_o, letter_end_o, word_end_o, busy_o}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        clr_counts();
        run(1'b0, 30);
        check("t6b_quiet", n_any, 0);
        run(1'b1, 4); cyc(1'b0); run(1'b0, 10); cyc(1'b0);
        check("t6b_fresh", 32'({letter_end_o, letter_code_o, letter_len_o, letter_err_o}),
              32'({1'b1, 6'b000000, 3'd1, 1'b0}));
        run(1'b0, 20);
        check("one_hot", n_multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_element_ctrl.md
Name: morse_element_ctrl

Overview:
- Sequences the decoder's timing path: measures debounced key-down and key-up intervals in Morse units and classifies them.
- Classification outputs: dot, dash, letter end and word end.
- Accumulates the dot/dash pattern of the current letter and hands it to the downstream character lookup with a one-cycle strobe.
- Sits between the key debouncer and the character decoder.

Parameters:
UNIT_TICKS, 1000, clock cycles per Morse unit; legal range >= 2.
DASH_UNITS, 2, press of at least this many whole units is a dash.
LETTER_GAP_UNITS, 3, key-up units that end a letter.
WORD_GAP_UNITS, 7, key-up units that end a word; must be > LETTER_GAP_UNITS.
MAX_UNITS, 15, saturation value of the unit counter; must be >= WORD_GAP_UNITS.
MAX_ELEMS, 6, maximum elements per letter.

Ports:
clk  in  1  system clock
reset  in  1  one clock; reset is asynchronous and active-high
key_i  in  1  debounced key level, synchronous to clk, 1 = pressed
dot_o  out  1  one-cycle pulse: dot classified
dash_o  out  1  one-cycle pulse: dash classified
letter_end_o  out  1  one-cycle pulse: letter complete; letter_code_o, letter_len_o and letter_err_o valid this cycle
letter_code_o  out  MAX_ELEMS  element pattern, dash = 1, first element in bit letter_len_o-1, LSB = last element
letter_len_o  out  $clog2(MAX_ELEMS+1)  element count of the letter
letter_err_o  out  1  letter had more than MAX_ELEMS elements
word_end_o  out  1  one-cycle pulse: word gap detected
busy_o  out  1  state != IDLE

Behaviour:
- Reset:
  - All outputs are 0; code, length and counters are 0; state is IDLE.
  - key_prev resets to 1, so a key already held at reset release is ignored until it is released.
- Interval measurement:
  - tick_cnt counts 0..UNIT_TICKS-1; unit_cnt increments on the tick_cnt wrap and saturates at MAX_UNITS, never wrapping.
  - On entering PRESS or GAP, tick_cnt loads 1 and unit_cnt loads 0, so the triggering sample is counted.
  - A level sampled L consecutive cycles measures floor(L/UNIT_TICKS) units, saturated.
- States:
  - IDLE: a key_i rising edge (key_i=1, key_prev=0) moves to PRESS.
  - PRESS: on the first key_i=0 sample, classify the measured units.
    - units >= DASH_UNITS gives a dash; otherwise a dot, including 0 units.
    - Pulse dot_o or dash_o in the next cycle.
    - Shift is_dash into the code register and increment the length, saturating at MAX_ELEMS.
    - If the length is already MAX_ELEMS, set sticky err instead; the code register is unchanged.
    - Go to GAP.
  - GAP: key_i=1 goes back to PRESS, intra-letter, with no output. When the measured gap reaches LETTER_GAP_UNITS:
    - Pulse letter_end_o with the current code, length and err.
    - Clear code, length and err the cycle after.
    - Go to WAIT_WORD; the counter keeps running and is not reloaded.
  - WAIT_WORD: key_i=1 goes to PRESS with no output. When the gap reaches WORD_GAP_UNITS, pulse word_end_o and go to IDLE.
- Timing:
  - Every pulse is registered, one cycle after the deciding sample.
  - letter_end_o asserts the cycle after key_i has been sampled low for LETTER_GAP_UNITS*UNIT_TICKS consecutive cycles; word_end_o likewise.
- Simultaneous events:
  - In GAP, if the threshold is reached in the same cycle key_i returns to 1, letter_end_o still fires and the state goes to PRESS.
  - The same rule applies in WAIT_WORD with word_end_o.
- Reset mid-operation: asynchronous clear. No pending pulse or partial letter survives.
- Only one of dot_o, dash_o, letter_end_o or word_end_o can pulse per cycle.

Decomposition:
- Shared package morse_pkg holds:
  - state enum ctrl_state_t {IDLE, PRESS, GAP, WAIT_WORD};
  - element enum elem_t {ELEM_DOT, ELEM_DASH};
  - default timing constants.
- One sub-module, unit_counter: the tick prescaler plus saturating unit counter, with a load input and units/threshold-compare outputs.

Test Plan:
All scenarios use UNIT_TICKS=4, DASH_UNITS=2, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7, MAX_UNITS=15, MAX_ELEMS=6.
1. Reset asserted with key_i=1, then released with the key still held for 20 cycles, then key low for 40 cycles -> all outputs 0 throughout, busy_o=0, no pulses.
2. Key high for 4, 7 and 8 cycles, each separated by 4 low cycles -> dot_o, dot_o, dash_o, each one cycle after the first low sample; no letter_end_o between them.
3. Dot (4), low 4, dash (8), low 12 -> letter_end_o one cycle after the 12th low sample; letter_code_o=6'b000001, letter_len_o=2, letter_err_o=0.
4. Single dot then low 28 cycles -> letter_end_o after low sample 12, word_end_o after low sample 28, then busy_o=0. Repeat with low 11 between two dots -> no letter_end_o.
5. Seven dots with 4-cycle gaps, then low 12 -> letter_len_o=6, letter_err_o=1, letter_code_o=0; the next letter starts with err clear.
6. Key held 100 cycles -> single dash_o (units saturated at 15, no wrap). Separately, assert reset mid-GAP after a dash -> outputs clear immediately; no letter_end_o follows.
